// File: rtl/display_scan_ctrl.sv
// Digit-scan divider and double-buffered frame store for the 4-digit display mux.
// Optional blink gating of the blank bits is enabled with `define DISP_BLINK_EN.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_hexs,
  input  logic [3:0]  wr_points,
  input  logic [3:0]  wr_les,
  input  logic [3:0]  blink_mask,
  output logic [1:0]  scan,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        pending,
  output logic        frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_scan;
  logic             r_frame_start;
  logic             r_pending;
  logic [15:0]      r_sh_hexs;
  logic [3:0]       r_sh_points;
  logic [3:0]       r_sh_les;
  logic [15:0]      r_hexs;
  logic [3:0]       r_points;
  logic [3:0]       r_act_les;

  logic             w_tick;
  logic             w_commit;
  logic [15:0]      w_nxt_hexs;
  logic [3:0]       w_nxt_points;
  logic [3:0]       w_nxt_les;

  assign w_tick   = (r_div_cnt == CNT_MAX);
  assign w_commit = w_tick && (r_scan == 2'd3);

  // Scan divider and digit index; the 3->0 wrap is the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt     <= '0;
      r_scan        <= 2'd0;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + CNT_W'(1);
      r_frame_start <= w_commit;
      if (w_tick) r_scan <= r_scan + 2'd1;
    end
  end

  // Shadow buffer: last host write wins until the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_hexs   <= '0;
      r_sh_points <= '0;
      r_sh_les    <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (wr_en) begin
        r_sh_hexs   <= wr_hexs;
        r_sh_points <= wr_points;
        r_sh_les    <= wr_les;
      end
      if (w_commit)   r_pending <= 1'b0;
      else if (wr_en) r_pending <= 1'b1;
    end
  end

  // A write landing in the commit cycle bypasses the shadow.
  always_comb begin
    w_nxt_hexs   = r_hexs;
    w_nxt_points = r_points;
    w_nxt_les    = r_act_les;
    if (w_commit) begin
      if (wr_en) begin
        w_nxt_hexs   = wr_hexs;
        w_nxt_points = wr_points;
        w_nxt_les    = wr_les;
      end else if (r_pending) begin
        w_nxt_hexs   = r_sh_hexs;
        w_nxt_points = r_sh_points;
        w_nxt_les    = r_sh_les;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hexs    <= '0;
      r_points  <= '0;
      r_act_les <= '0;
    end else begin
      r_hexs    <= w_nxt_hexs;
      r_points  <= w_nxt_points;
      r_act_les <= w_nxt_les;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_DIV - 1);

  logic [FC_W-1:0] r_fc;
  logic            r_blink_off;
  logic [3:0]      r_les;
  logic            w_blink_nxt;

  assign w_blink_nxt = (w_commit && (r_fc == FC_MAX)) ? ~r_blink_off : r_blink_off;

  // Frame counter toggles the blink phase; gated blanks refresh only at commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc        <= '0;
      r_blink_off <= 1'b0;
      r_les       <= '0;
    end else if (w_commit) begin
      r_fc        <= (r_fc == FC_MAX) ? '0 : r_fc + FC_W'(1);
      r_blink_off <= w_blink_nxt;
      r_les       <= w_nxt_les | (w_blink_nxt ? blink_mask : 4'b0000);
    end
  end

  assign LEs = r_les;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^{blink_mask, 32'(BLINK_DIV)};
  assign LEs = r_act_les;
`endif

  assign scan        = r_scan;
  assign hexs        = r_hexs;
  assign points      = r_points;
  assign pending     = r_pending;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: scan timing, deferred/overwrite/bypass commits, reset, blink.
// Blink expectations follow `define DISP_BLINK_EN when the build defines it.
module tb_display_scan_ctrl;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 2;
  localparam int unsigned FRAME     = 4 * SCAN_DIV;
  localparam int unsigned NO_WR     = 99;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_hexs;
  logic [3:0]  wr_points;
  logic [3:0]  wr_les;
  logic [3:0]  blink_mask;
  logic [1:0]  scan;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  les;
  logic        pending;
  logic        frame_start;
  logic [1:0]  scan1;
  logic [15:0] hexs1;
  logic [3:0]  points1;
  logic [3:0]  les1;
  logic        pending1;
  logic        frame_start1;

  display_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_hexs(wr_hexs), .wr_points(wr_points),
    .wr_les(wr_les), .blink_mask(blink_mask), .scan(scan), .hexs(hexs), .points(points),
    .LEs(les), .pending(pending), .frame_start(frame_start)
  );

  display_scan_ctrl #(.SCAN_DIV(1), .BLINK_DIV(BLINK_DIV)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_hexs(wr_hexs), .wr_points(wr_points),
    .wr_les(wr_les), .blink_mask(blink_mask), .scan(scan1), .hexs(hexs1), .points(points1),
    .LEs(les1), .pending(pending1), .frame_start(frame_start1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned pos_a;
    logic [23:0] dat_a;   // {les, points, hexs}
    int unsigned pos_b;
    logic [23:0] dat_b;
    logic [15:0] e_hexs;
    logic [3:0]  e_points;
    logic [3:0]  e_les;
  } row_t;

  typedef struct {
    logic [15:0] h;
    logic [3:0]  p;
    logic [3:0]  l;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned k        = 0;
  exp_t        sb[$];
  exp_t        cur;
  logic [15:0] prev_h;
  row_t        rows[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
  endtask

  task automatic next();
    @(negedge clk);
    k++;
  endtask

  function automatic logic blink_on(input int unsigned n_commits);
`ifdef DISP_BLINK_EN
    return ((n_commits / BLINK_DIV) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] exp_les(input logic [3:0] act_les, input int unsigned n);
    return act_les | (blink_on(n) ? blink_mask : 4'b0000);
  endfunction

  task automatic pop_and_check();
    cur = sb.pop_front();
    check("commit_fs",     32'(frame_start), 32'(1));
    check("commit_scan",   32'(scan),        32'(0));
    check("commit_pend",   32'(pending),     32'(0));
    check("commit_hexs",   32'(hexs),        32'(cur.h));
    check("commit_points", 32'(points),      32'(cur.p));
    check("commit_les",    32'(les),         32'(exp_les(cur.l, k / FRAME)));
    prev_h = cur.h;
  endtask

  initial begin
    rows[0] = '{5,  {4'h0, 4'h0, 16'h1234}, NO_WR, 24'h0,                   16'h1234, 4'h0, 4'h0};
    rows[1] = '{2,  {4'h0, 4'h0, 16'hAAAA}, 9,     {4'h0, 4'h0, 16'h5555}, 16'h5555, 4'h0, 4'h0};
    rows[2] = '{15, {4'h1, 4'hA, 16'hBEEF}, NO_WR, 24'h0,                   16'hBEEF, 4'hA, 4'h1};
    rows[3] = '{NO_WR, 24'h0,               NO_WR, 24'h0,                   16'hBEEF, 4'hA, 4'h1};
    rows[4] = '{0,  {4'h0, 4'h5, 16'hC0DE}, NO_WR, 24'h0,                   16'hC0DE, 4'h5, 4'h0};

    rst = 1'b1; wr_en = 1'b0; wr_hexs = '0; wr_points = '0; wr_les = '0; blink_mask = 4'b0101;
    prev_h = '0;
    #2;
    check("rst_scan",   32'(scan),        32'(0));
    check("rst_hexs",   32'(hexs),        32'(0));
    check("rst_les",    32'(les),         32'(0));
    check("rst_pend",   32'(pending),     32'(0));
    check("rst_fs",     32'(frame_start), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    k = 0;

    // Free-running scan, main and divide-by-1 instances
    for (int i = 0; i < 32; i++) begin
      next();
      check("run_scan",  32'(scan),         32'((k / SCAN_DIV) % 4));
      check("run_fs",    32'(frame_start),  32'(k % FRAME == 0));
      check("div1_scan", 32'(scan1),        32'(k % 4));
      check("div1_fs",   32'(frame_start1), 32'(k % 4 == 0));
    end

    // Table-driven frames; expected frame pushed when stimulus starts, popped at frame_start
    for (int r = 0; r < 5; r++) begin
      for (int unsigned pos = 0; pos < FRAME; pos++) begin
        if (pos == 0) begin
          if (sb.size() > 0) pop_and_check();
          sb.push_back('{rows[r].e_hexs, rows[r].e_points, rows[r].e_les});
        end
        if (pos == rows[r].pos_a + 1 || pos == rows[r].pos_b + 1) begin
          check("mid_pend", 32'(pending), 32'(1));
          check("mid_hexs", 32'(hexs),    32'(prev_h));
        end
        wr_en = 1'b0;
        if (pos == rows[r].pos_a) begin
          wr_en = 1'b1;
          {wr_les, wr_points, wr_hexs} = rows[r].dat_a;
        end else if (pos == rows[r].pos_b) begin
          wr_en = 1'b1;
          {wr_les, wr_points, wr_hexs} = rows[r].dat_b;
        end
        next();
      end
    end
    wr_en = 1'b0;
    pop_and_check();

    // Idle frames: blink phase on LEs, active frame unchanged
    for (int f = 0; f < 4; f++) begin
      repeat (FRAME) next();
      check("idle_fs",   32'(frame_start), 32'(1));
      check("idle_hexs", 32'(hexs),        32'(16'hC0DE));
      check("blink_les", 32'(les),         32'(exp_les(4'h0, k / FRAME)));
    end

    // Reset mid-write discards the pending frame and restarts the scan
    repeat (3) next();
    wr_en = 1'b1; wr_hexs = 16'h9999; wr_points = 4'hF; wr_les = 4'h0;
    next();
    wr_en = 1'b0;
    check("pre_rst_pend", 32'(pending), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_scan",  32'(scan),        32'(0));
    check("arst_hexs",  32'(hexs),        32'(0));
    check("arst_pts",   32'(points),      32'(0));
    check("arst_les",   32'(les),         32'(0));
    check("arst_pend",  32'(pending),     32'(0));
    check("arst_fs",    32'(frame_start), 32'(0));
    check("arst_scan1", 32'(scan1),       32'(0));
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (3) next();
    check("post_rst_scan3", 32'(scan), 32'(0));
    next();
    check("post_rst_scan4", 32'(scan), 32'(1));
    repeat (FRAME - 4) next();
    check("post_rst_fs",   32'(frame_start), 32'(1));
    check("post_rst_pend", 32'(pending),     32'(0));
    check("post_rst_hexs", 32'(hexs),        32'(0));
    check("post_rst_les",  32'(les),         32'(exp_les(4'h0, k / FRAME)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
